// File: rtl/ram_pkg.sv
// Shared sizing and write-arbitration types for the compute-RAM block RAM.
// Defaults here also size the system wrapper.
package ram_pkg;

  localparam int BRAM_DWIDTH = 40;
  localparam int BRAM_AWIDTH = 9;
  localparam int BRAM_DEPTH  = 512;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_P1   = 2'b01,
    WR_P2   = 2'b10,
    WR_BOTH = 2'b11
  } wr_sel_e;

  // Port 2 owns the word when both ports write the same address.
  function automatic wr_sel_e wr_arbitrate(
    input logic we1,
    input logic we2,
    input logic same_addr
  );
    wr_sel_e sel;
    sel = WR_NONE;
    if (we1 && we2)
      sel = same_addr ? WR_P2 : WR_BOTH;
    else if (we1)
      sel = WR_P1;
    else if (we2)
      sel = WR_P2;
    return sel;
  endfunction

endpackage

// File: rtl/dual_port_ram_port.sv
// One port's registered read output: loads on reads, holds on writes,
// cleared asynchronously by reset.
module ram_port
  import ram_pkg::*;
#(
  parameter int DWIDTH = BRAM_DWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] out
);

  logic [DWIDTH-1:0] out_d;
  logic [DWIDTH-1:0] out_q;

  always_comb begin
    out_d = out_q;
    if (!we)
      out_d = rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out_q <= '0;
    else
      out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with a registered read output per port.
// Cross-port reads see the pre-write word; port 2 wins dual writes.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int DWIDTH = BRAM_DWIDTH,
  parameter int AWIDTH = BRAM_AWIDTH,
  parameter int DEPTH  = BRAM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] addr1,
  input  logic              we1,
  input  logic [DWIDTH-1:0] data1,
  output logic [DWIDTH-1:0] out1,
  input  logic [AWIDTH-1:0] addr2,
  input  logic              we2,
  input  logic [DWIDTH-1:0] data2,
  output logic [DWIDTH-1:0] out2
);

  logic [DWIDTH-1:0] mem [DEPTH];

  wr_sel_e           wr_sel;
  logic [DWIDTH-1:0] rd1;
  logic [DWIDTH-1:0] rd2;

  // Writes are dropped while reset is held; contents are never cleared.
  always_comb begin
    wr_sel = WR_NONE;
    if (!reset)
      wr_sel = wr_arbitrate(we1, we2, addr1 == addr2);
  end

  always_ff @(posedge clk) begin
    unique case (wr_sel)
      WR_P1:   mem[addr1] <= data1;
      WR_P2:   mem[addr2] <= data2;
      WR_BOTH: begin
        mem[addr1] <= data1;
        mem[addr2] <= data2;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd1 = mem[addr1];
    rd2 = mem[addr2];
  end

  ram_port #(.DWIDTH(DWIDTH)) u_port1 (
    .clk     (clk),
    .reset   (reset),
    .we      (we1),
    .rd_data (rd1),
    .out     (out1)
  );

  ram_port #(.DWIDTH(DWIDTH)) u_port2 (
    .clk     (clk),
    .reset   (reset),
    .we      (we2),
    .rd_data (rd2),
    .out     (out2)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: read/write, collisions, async reset
// and a full-depth streaming read on port 2.
module tb_dual_port_ram;

  localparam int DW = 40;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr1;
  logic          we1;
  logic [DW-1:0] data1;
  logic [DW-1:0] out1;
  logic [AW-1:0] addr2;
  logic          we2;
  logic [DW-1:0] data2;
  logic [DW-1:0] out2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DW-1:0] V5 = 40'hA5_1234_5678;

  always #5 clk = ~clk;

  dual_port_ram dut (
    .clk   (clk),
    .reset (reset),
    .addr1 (addr1),
    .we1   (we1),
    .data1 (data1),
    .out1  (out1),
    .addr2 (addr2),
    .we2   (we2),
    .data2 (data2),
    .out2  (out2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we1 = 1'b0;
    we2 = 1'b0;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we1   = 1'b1;
    addr1 = a;
    data1 = d;
    we2   = 1'b0;
    step();
    we1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    addr1 = '0;
    addr2 = '0;
    data1 = '0;
    data2 = '0;
    idle();
    step();
    step();
    check("reset_out1", out1, '0);
    check("reset_out2", out2, '0);
    reset = 1'b0;

    // write/read-back on both ports
    wr1(9'd5, V5);
    addr1 = 9'd5;
    addr2 = 9'd5;
    step();
    check("rb_out1", out1, V5);
    check("rb_out2", out2, V5);

    // a write cycle holds the read register
    wr1(9'd3, 40'h11);
    addr1 = 9'd3;
    step();
    check("read3", out1, 40'h11);
    wr1(9'd7, 40'h22);
    check("hold_on_wr", out1, 40'h11);
    addr1 = 9'd7;
    step();
    check("read7", out1, 40'h22);

    // cross-port collision returns old word
    wr1(9'd9, 40'h1);
    we1   = 1'b1;
    addr1 = 9'd9;
    data1 = 40'h2;
    we2   = 1'b0;
    addr2 = 9'd9;
    step();
    check("coll_old", out2, 40'h1);
    idle();
    step();
    check("coll_new", out2, 40'h2);
    check("coll_p1rd", out1, 40'h2);

    // dual write, port 2 wins
    we1   = 1'b1;
    we2   = 1'b1;
    addr1 = 9'd12;
    addr2 = 9'd12;
    data1 = 40'hAA;
    data2 = 40'hBB;
    step();
    check("dw_hold1", out1, 40'h2);
    check("dw_hold2", out2, 40'h2);
    idle();
    step();
    check("dw_out1", out1, 40'hBB);
    check("dw_out2", out2, 40'hBB);

    // async reset between edges, writes ignored while held
    #2 reset = 1'b1;
    #1;
    check("arst_out1", out1, '0);
    check("arst_out2", out2, '0);
    we1   = 1'b1;
    addr1 = 9'd5;
    data1 = 40'hDE_ADBE_EF00;
    step();
    check("rst_hold1", out1, '0);
    check("rst_hold2", out2, '0);
    idle();
    #2 reset = 1'b0;
    addr1 = 9'd5;
    addr2 = 9'd5;
    step();
    check("keep_out1", out1, V5);
    check("keep_out2", out2, V5);

    // boundaries, then fill the rest and stream port 2
    wr1(9'd0, 40'd0);
    wr1(9'd511, 40'd511);
    addr2 = 9'd0;
    step();
    check("bnd_lo", out2, 40'd0);
    addr2 = 9'd511;
    step();
    check("bnd_hi", out2, 40'd511);
    for (int i = 1; i < 511; i++)
      wr1(AW'(i), {8'h5A, 32'(i)});
    for (int i = 0; i < 512; i++) begin
      logic [DW-1:0] e;
      if (i == 0 || i == 511)
        e = DW'(i);
      else
        e = {8'h5A, 32'(i)};
      addr2 = AW'(i);
      step();
      check($sformatf("sweep_%0d", i), out2, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
